// File: rtl/lcd_bus_monitor.sv
// Passive receiver for the 4-bit HD44780-style LCD bus: follows the init ghost
// sequence, assembles nibble pairs, decodes commands and keeps a 32-char shadow.
module lcd_bus_monitor #(
  parameter int MIN_E_HIGH     = 12,
  parameter int NIBBLE_TIMEOUT = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic         lcd_4,
  input  logic         lcd_5,
  input  logic         lcd_6,
  input  logic         lcd_7,
  output logic [255:0] chars,
  output logic [6:0]   cursor_addr,
  output logic         display_on,
  output logic         init_done,
  output logic         cmd_valid,
  output logic [7:0]   cmd_byte,
  output logic         data_valid,
  output logic         glitch,
  output logic         err
);

  localparam int              HW_W   = $clog2(MIN_E_HIGH + 1);
  localparam logic [HW_W-1:0] HW_MAX = HW_W'(MIN_E_HIGH);
  localparam logic [19:0]     TO_MAX = 20'(NIBBLE_TIMEOUT);
  localparam logic [255:0]    BLANK  = {32{8'h20}};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // DDRAM address walk: the two 40-byte line windows are joined end to end.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // pin vectors are {rs, rw, e, d7, d6, d5, d4}
  logic [6:0]      sync1_q, sync2_q, prev_q;
  logic [HW_W-1:0] hw_q, hw_d;
  logic [19:0]     to_q, to_d;
  state_t          state_q, state_d;
  logic [3:0]      hi_nib_q, hi_nib_d;
  logic [255:0]    chars_q, chars_d;
  logic [6:0]      cursor_q, cursor_d;
  logic            inc_q, inc_d;
  logic            disp_q, disp_d;
  logic            init_q, init_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            data_valid_q, data_valid_d;
  logic            glitch_q, glitch_d;
  logic            err_q, err_d;

  logic       fall_s, short_s, strobe_s, rs_s;
  logic [3:0] nib_s;
  logic [7:0] byte_s;
  logic [4:0] slot_s;

  // two-flop synchronizer plus one delay stage holding the last high-e sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 7'd0;
      sync2_q <= 7'd0;
      prev_q  <= 7'd0;
    end else begin
      sync1_q <= {lcd_rs, lcd_rw, lcd_e, lcd_7, lcd_6, lcd_5, lcd_4};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_s   = prev_q[4] & ~sync2_q[4];
  assign short_s  = fall_s & (hw_q < HW_MAX);
  assign strobe_s = fall_s & ~short_s & ~prev_q[5];
  assign rs_s     = prev_q[6];
  assign nib_s    = prev_q[3:0];
  assign byte_s   = {hi_nib_q, nib_s};
  assign slot_s   = {cursor_q[6], cursor_q[3:0]};

  // strobe high-width and inter-nibble timeout counters
  always_comb begin
    if (sync2_q[4]) begin
      hw_d = (hw_q == HW_MAX) ? hw_q : hw_q + {{(HW_W-1){1'b0}}, 1'b1};
    end else begin
      hw_d = {HW_W{1'b0}};
    end
    if (state_q == ST_LO) begin
      to_d = (to_q == TO_MAX) ? to_q : to_q + 20'd1;
    end else begin
      to_d = 20'd0;
    end
  end

  // protocol state machine and byte execution
  always_comb begin
    state_d      = state_q;
    hi_nib_d     = hi_nib_q;
    chars_d      = chars_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    disp_d       = disp_q;
    init_d       = init_q;
    cmd_byte_d   = cmd_byte_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    glitch_d     = short_s;
    err_d        = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (strobe_s) begin
          if (nib_s == 4'h2) begin
            state_d = ST_HI;
            init_d  = 1'b1;
          end else if (nib_s != 4'h3) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_HI: begin
        if (strobe_s) begin
          hi_nib_d = nib_s;
          state_d  = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (strobe_s) begin
          state_d = ST_HI;
          if (rs_s) begin
            data_valid_d = 1'b1;
            if (cursor_q[5:4] == 2'b00) begin
              chars_d[{5'd31 - slot_s, 3'b000} +: 8] = byte_s;
            end else begin
              chars_d = chars_q;
            end
            cursor_d = addr_step(cursor_q, inc_q);
          end else begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_s;
            if (byte_s[7]) begin
              if (addr_ok(byte_s[6:0])) cursor_d = byte_s[6:0];
              else                      err_d    = 1'b1;
            end else if (byte_s[6:4] != 3'd0) begin
              cursor_d = cursor_q;
            end else if (byte_s[3]) begin
              disp_d = byte_s[2];
            end else if (byte_s[2]) begin
              inc_d = byte_s[1];
            end else if (byte_s[1]) begin
              cursor_d = 7'd0;
            end else if (byte_s[0]) begin
              chars_d  = BLANK;
              cursor_d = 7'd0;
              inc_d    = 1'b1;
            end else begin
              cursor_d = cursor_q;
            end
          end
        end else if (to_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = ST_HI;
        end else begin
          state_d = ST_LO;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q         <= {HW_W{1'b0}};
      to_q         <= 20'd0;
      state_q      <= ST_INIT;
      hi_nib_q     <= 4'd0;
      chars_q      <= BLANK;
      cursor_q     <= 7'd0;
      inc_q        <= 1'b1;
      disp_q       <= 1'b0;
      init_q       <= 1'b0;
      cmd_byte_q   <= 8'd0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      glitch_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hw_q         <= hw_d;
      to_q         <= to_d;
      state_q      <= state_d;
      hi_nib_q     <= hi_nib_d;
      chars_q      <= chars_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      disp_q       <= disp_d;
      init_q       <= init_d;
      cmd_byte_q   <= cmd_byte_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      glitch_q     <= glitch_d;
      err_q        <= err_d;
    end
  end

  assign chars       = chars_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign init_done   = init_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign data_valid  = data_valid_q;
  assign glitch      = glitch_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: a character-array model predicts every
// pulse and the display state that accompanies it.
module tb_lcd_bus_monitor;

  localparam int MIN_E = 12;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic lcd_4 = 1'b0, lcd_5 = 1'b0, lcd_6 = 1'b0, lcd_7 = 1'b0;
  logic [255:0] chars;
  logic [6:0]   cursor_addr;
  logic         display_on, init_done, cmd_valid, data_valid, glitch, err;
  logic [7:0]   cmd_byte;

  always #5 clk = ~clk;

  lcd_bus_monitor #(.MIN_E_HIGH(MIN_E), .NIBBLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
    .chars(chars), .cursor_addr(cursor_addr), .display_on(display_on),
    .init_done(init_done), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .data_valid(data_valid), .glitch(glitch), .err(err)
  );

  typedef struct packed {
    logic         cv;
    logic         dv;
    logic         gl;
    logic         er;
    logic [7:0]   cb;
    logic [6:0]   cur;
    logic         don;
    logic         idn;
    logic [255:0] ch;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  logic [255:0] blank = {32{8'h20}};

  // reference model state
  logic [7:0] m_chars[32];
  int         m_cur;
  bit         m_inc, m_disp, m_init;
  logic [7:0] m_cmd;
  int         m_phase;   // 0 = 8-bit init, 1 = expecting high nibble, 2 = low nibble
  logic [3:0] m_hi;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
    m_cur = 0; m_inc = 1'b1; m_disp = 1'b0; m_init = 1'b0;
    m_cmd = 8'h00; m_phase = 0; m_hi = 4'h0;
  endfunction

  function automatic ev_t snap(bit cv, bit dv, bit gl, bit er);
    ev_t e;
    e.cv = cv; e.dv = dv; e.gl = gl; e.er = er;
    e.cb = m_cmd; e.cur = 7'(m_cur); e.don = m_disp; e.idn = m_init;
    for (int i = 0; i < 32; i++) e.ch[255 - 8*i -: 8] = m_chars[i];
    return e;
  endfunction

  function automatic bit valid_addr(int a);
    return (a <= 39) || (a >= 64 && a <= 103);
  endfunction

  function automatic void model_byte(bit rs, logic [7:0] b);
    bit er = 1'b0;
    if (rs) begin
      if (m_cur <= 15) m_chars[m_cur] = b;
      else if (m_cur >= 64 && m_cur <= 79) m_chars[m_cur - 48] = b;
      if (m_inc) m_cur = (m_cur == 39) ? 64 : (m_cur == 103) ? 0 : m_cur + 1;
      else       m_cur = (m_cur == 0) ? 103 : (m_cur == 64) ? 39 : m_cur - 1;
      exp_q.push_back(snap(1'b0, 1'b1, 1'b0, 1'b0));
    end else begin
      m_cmd = b;
      if (b == 8'h01) begin
        for (int i = 0; i < 32; i++) m_chars[i] = 8'h20;
        m_cur = 0; m_inc = 1'b1;
      end else if (b == 8'h02 || b == 8'h03) m_cur = 0;
      else if (b >= 8'h04 && b <= 8'h07) m_inc = b[1];
      else if (b >= 8'h08 && b <= 8'h0F) m_disp = b[2];
      else if (b >= 8'h80) begin
        if (valid_addr(int'(b) - 128)) m_cur = int'(b) - 128;
        else er = 1'b1;
      end
      exp_q.push_back(snap(1'b1, 1'b0, 1'b0, er));
    end
  endfunction

  function automatic void model_nib(bit rs, bit rw, logic [3:0] nib, int hi);
    if (hi < MIN_E) exp_q.push_back(snap(1'b0, 1'b0, 1'b1, 1'b0));
    else if (!rw) begin
      if (m_phase == 0) begin
        if (nib == 4'h2) begin m_phase = 1; m_init = 1'b1; end
        else if (nib != 4'h3) exp_q.push_back(snap(1'b0, 1'b0, 1'b0, 1'b1));
      end else if (m_phase == 1) begin
        m_hi = nib; m_phase = 2;
      end else begin
        m_phase = 1;
        model_byte(rs, {m_hi, nib});
      end
    end
  endfunction

  task automatic drive_nib(bit rs, bit rw, logic [3:0] nib, int hi);
    model_nib(rs, rw, nib, hi);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; {lcd_7, lcd_6, lcd_5, lcd_4} = nib; lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(bit rs, logic [7:0] b);
    drive_nib(rs, 1'b0, b[7:4], 13);
    drive_nib(rs, 1'b0, b[3:0], 13);
  endtask

  task automatic check(string name, logic [255:0] act, logic [255:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic monitor();
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (rst_n && (cmd_valid || data_valid || glitch || err)) begin
        act.cv = cmd_valid; act.dv = data_valid; act.gl = glitch; act.er = err;
        act.cb = cmd_byte; act.cur = cursor_addr; act.don = display_on;
        act.idn = init_done; act.ch = chars;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got %h expected no pulse", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL pulse_event: got %h expected %h", act, e);
          end
        end
      end
    end
  endtask

  task automatic do_init();
    drive_nib(1'b0, 1'b0, 4'h3, 13);
    drive_nib(1'b0, 1'b0, 4'h3, 13);
    drive_nib(1'b0, 1'b0, 4'h3, 13);
    drive_nib(1'b0, 1'b0, 4'h2, 13);
  endtask

  initial begin
    logic [7:0] b;
    int op, w, a;
    model_reset();
    fork monitor(); join_none
    repeat (4) @(negedge clk);
    check("reset_chars", chars, blank);
    check("reset_cursor", 256'(cursor_addr), 256'd0);
    check("reset_display_on", 256'(display_on), 256'd0);
    check("reset_init_done", 256'(init_done), 256'd0);
    check("reset_cmd_byte", 256'(cmd_byte), 256'd0);
    check("reset_pulses", 256'({cmd_valid, data_valid, glitch, err}), 256'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_init();
    check("init_done_set", 256'(init_done), 256'd1);
    check("init_chars", chars, blank);

    send_byte(1'b0, 8'h28); send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h01);
    check("cfg_cmd_byte", 256'(cmd_byte), 256'h01);
    check("cfg_display_on", 256'(display_on), 256'd1);
    check("cfg_cursor", 256'(cursor_addr), 256'd0);

    send_byte(1'b1, 8'h48); send_byte(1'b1, 8'h45); send_byte(1'b1, 8'h4C);
    send_byte(1'b1, 8'h4C); send_byte(1'b1, 8'h4F);
    send_byte(1'b0, 8'hC0);
    send_byte(1'b1, 8'h41); send_byte(1'b1, 8'h42);
    check("hello_line1", 256'(chars[255:216]), 256'h48454C4C4F);
    check("ab_line2", 256'(chars[127:112]), 256'h4142);
    check("cursor_after_ab", 256'(cursor_addr), 256'h42);

    drive_nib(1'b0, 1'b0, 4'h4, 5);
    drive_nib(1'b0, 1'b0, 4'h4, 11);
    drive_nib(1'b1, 1'b0, 4'h4, 12);
    drive_nib(1'b1, 1'b0, 4'h3, 12);

    drive_nib(1'b1, 1'b0, 4'h4, 13);
    m_phase = 1;
    exp_q.push_back(snap(1'b0, 1'b0, 1'b0, 1'b1));
    repeat (TMO + 10) @(negedge clk);
    send_byte(1'b1, 8'h41);
    check("line2_abca", 256'(chars[127:96]), 256'h41424341);

    send_byte(1'b0, 8'hB0);
    check("bad_addr_cursor", 256'(cursor_addr), 256'h44);
    drive_nib(1'b0, 1'b1, 4'h8, 13);
    send_byte(1'b1, 8'h5A);
    drain();

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      w  = $urandom_range(12, 16);
      case (op)
        0: begin
          a = $urandom_range(0, 3);
          b = (a == 0) ? 8'h01 : (a == 1) ? 8'h02 : (a == 2) ? 8'h03 : 8'($urandom_range(16, 127));
          send_byte(1'b0, b);
        end
        1: send_byte(1'b0, 8'(8'h04 | 8'($urandom_range(0, 3))));
        2: send_byte(1'b0, 8'(8'h08 | 8'($urandom_range(0, 7))));
        3: begin
          a = $urandom_range(0, 79);
          if (a >= 40) a = a - 40 + 64;
          send_byte(1'b0, 8'(8'h80 | 8'(a)));
        end
        4: send_byte(1'b0, 8'(8'h80 | 8'($urandom_range(0, 127))));
        5: drive_nib(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)), $urandom_range(1, 11));
        6: drive_nib(1'b0, 1'b1, 4'($urandom_range(0, 15)), 13);
        default: begin
          b = 8'($urandom_range(32, 126));
          drive_nib(1'b1, 1'b0, b[7:4], w);
          if ($urandom_range(0, 3) == 0)
            drive_nib(1'b0, 1'b0, 4'($urandom_range(0, 15)), $urandom_range(1, 11));
          if ($urandom_range(0, 3) == 0)
            drive_nib(1'b0, 1'b1, 4'($urandom_range(0, 15)), 13);
          drive_nib(1'b1, 1'b0, b[3:0], w);
        end
      endcase
    end
    drain();

    drive_nib(1'b1, 1'b0, 4'h4, 13);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midbyte_reset_chars", chars, blank);
    check("midbyte_reset_cursor", 256'(cursor_addr), 256'd0);
    check("midbyte_reset_init", 256'(init_done), 256'd0);
    check("midbyte_reset_display", 256'(display_on), 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drive_nib(1'b0, 1'b0, 4'h5, 13);
    do_init();
    send_byte(1'b1, 8'h51);
    check("post_reset_char", 256'(chars[255:248]), 256'h51);
    check("post_reset_cursor", 256'(cursor_addr), 256'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Listening end of the HD44780-style 4-bit LCD bus that our LCD driver produces. Passive receiver: samples lcd_rs/lcd_rw/lcd_e/lcd_4..7, follows the power-on 8-bit ghost sequence, and assembles nibble pairs into bytes.
- Decodes commands and keeps a 32-character shadow of the display as a 256-bit vector, in the same layout the driver consumes.
- Used as an on-chip checker and as the bench model for LCD-facing blocks.

Parameters:
- MIN_E_HIGH, 12, minimum synchronized lcd_e high width in clk cycles; shorter strobes are discarded.
- NIBBLE_TIMEOUT, 1_000_000, maximum clk cycles allowed between the high and low nibble (20-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_rs, lcd_rw, lcd_e  in  1 each  LCD control pins
- lcd_4, lcd_5, lcd_6, lcd_7  in  1 each  data nibble; lcd_7 is the MSB
- chars  out  256  shadow display. [255:248] = line 1 col 0 … [135:128] = line 1 col 15; [127:120] = line 2 col 0 … [7:0] = line 2 col 15
- cursor_addr  out  7  current DDRAM address
- display_on  out  1  D bit from the last display-control command
- init_done  out  1  set when 4-bit mode is entered
- cmd_valid  out  1  one-cycle pulse; cmd_byte holds the decoded command
- cmd_byte  out  8  last command byte (rs=0)
- data_valid  out  1  one-cycle pulse per character byte written (rs=1)
- glitch  out  1  one-cycle pulse: strobe shorter than MIN_E_HIGH
- err  out  1  one-cycle pulse: bad init nibble, invalid DDRAM address, or nibble timeout

Behaviour:
- Reset (async, rst_n=0):
  - chars = 32 x 8'h20.
  - cursor_addr = 0, display_on = 0, init_done = 0, cmd_byte = 0, increment flag = 1.
  - All pulses 0, state INIT.
  - Reset mid-byte discards any partial nibble.
- Input synchronization:
  - All 7 pins pass through a 2-flop synchronizer.
  - Strobe = falling edge of synchronized e.
  - rs, rw and the nibble are taken from the synchronized stage aligned with the last high e sample.
- Latency: if edge k is the first clk edge that samples lcd_e low, all resulting register and output updates occur at edge k+2. Pulses are high for exactly one cycle after k+2.
- Strobe qualification:
  - A high-width counter saturates at MIN_E_HIGH.
  - Fall with count < MIN_E_HIGH: glitch pulse, strobe ignored, no state change.
  - Strobes with rw=1 are ignored entirely and do not advance the nibble phase.
- State machine:
  - INIT (8-bit mode, one nibble = one command):
    - nibble 3: stay in INIT.
    - nibble 2: go to HI, init_done <= 1.
    - any other nibble: err pulse, stay in INIT.
  - HI: store the nibble as byte[7:4], go to LO, clear the timeout counter.
  - LO: nibble becomes byte[3:0], execute the byte, go to HI.
    - Timeout counter reaching NIBBLE_TIMEOUT in LO: err pulse, discard the high nibble, go to HI.
    - A strobe in the same cycle as the timeout wins: the byte completes.
- Command execution (rs=0; cmd_valid pulses, cmd_byte updated for every command):
  - 8'h01: chars = all 8'h20, cursor_addr = 0, increment = 1.
  - 8'h02 / 8'h03: cursor_addr = 0.
  - 8'h04–8'h07: increment = bit1.
  - 8'h08–8'h0F: display_on = bit2.
  - 8'h10–8'h7F: no internal effect.
  - 8'h80 | a: set cursor_addr = a.
    - Valid a: 0x00–0x27 and 0x40–0x67.
    - Any other a: err pulse, cursor unchanged.
- Data write (rs=1, data_valid pulses):
  - cursor 0x00–0x0F updates chars slot = cursor; 0x40–0x4F updates slot 16+(cursor−0x40).
  - Other valid addresses are stored nowhere.
  - Then cursor advances:
    - increment=1: 0x27→0x40, 0x67→0x00, else +1.
    - increment=0: 0x00→0x67, 0x40→0x27, else −1.
- A new strobe arriving while pulses are high is processed normally; pulses may be high back-to-back.

Test Plan:
- Reset, then nibbles 3,3,3,2 with 13-cycle e pulses → init_done=1 after the 4th strobe; chars = all 8'h20; err never pulses.
- After init, send bytes 0x28, 0x06, 0x0C, 0x01 → four cmd_valid pulses; cmd_byte = 0x01 at the end; display_on=1; cursor_addr=0.
- Write "HELLO" (rs=1), send 0xC0, write "AB" → chars[255:216] = "HELLO"; chars[127:112] = "AB"; cursor_addr = 0x42.
- 5-cycle e pulse carrying nibble 4 → glitch pulses once; nibble phase unchanged; the next valid pair decodes correctly.
- High nibble 4, then wait NIBBLE_TIMEOUT+10 cycles → one err pulse; the following pair 0x41 writes 'A' at the cursor.
- Command 0x80 | 0x30 → err pulse; cursor unchanged. Assert rst_n=0 between nibbles → immediate reset values; state INIT.
